// File: rtl/branch_resolver.sv
// Branch resolver: keeps in-flight predictor outcomes in an in-order FIFO, compares each one with the
// resolved direction, and produces the predictor update, the mispredict flush and the hit/miss statistics.
module branch_resolver #(
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pred_valid,
    input  logic                     pred_taken,
    output logic                     pred_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     upd_valid,
    output logic                     upd_taken,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CW-1:0]            hit_count,
    output logic [CW-1:0]            miss_count,
    output logic                     err_underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      count;
    logic [PW:0]      count_nxt;

    logic push;
    logic pop;
    logic head_taken;
    logic mis;

    // Ready looks only at the registered count, so a full queue refuses a push even while it pops.
    assign pred_ready = (count < FULL);
    assign occupancy  = count;

    assign push       = pred_valid && pred_ready;
    assign pop        = res_valid && (count != '0);
    assign head_taken = mem[head];
    assign mis        = pop && (head_taken != res_taken);

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        count_nxt = count;
        if (mis) begin
            count_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: count_nxt = count;
            endcase
        end
    end

    // NOTE: the entry storage has no reset; an entry is only read while count says it holds a live value.
    always_ff @(posedge clk) begin
        if (push && !mis) begin
            mem[tail] <= pred_taken;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            count <= count_nxt;
            if (mis) begin
                // Wrong path: drop everything queued and the same-cycle push.
                head <= tail;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid     <= 1'b0;
            upd_taken     <= 1'b0;
            mispredict    <= 1'b0;
            hit_count     <= '0;
            miss_count    <= '0;
            err_underflow <= 1'b0;
        end else begin
            upd_valid  <= pop;
            mispredict <= mis;
            if (pop) upd_taken <= res_taken;
            if (res_valid && (count == '0)) err_underflow <= 1'b1;
            if (pop && !mis && (hit_count != CNT_MAX))  hit_count  <= hit_count + 1'b1;
            if (mis && (miss_count != CNT_MAX))         miss_count <= miss_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: a vector table for the main DUT plus hand sequences for
// asynchronous mid-cycle reset and counter saturation (second instance with 2-bit counters).
module tb_branch_resolver;

    logic clk = 1'b0;
    logic rst_n;

    logic       pred_valid, pred_taken, res_valid, res_taken;
    logic       pred_ready, upd_valid, upd_taken, mispredict, err_underflow;
    logic [2:0] occupancy;
    logic [15:0] hit_count, miss_count;

    logic       b_pred_valid, b_pred_taken, b_res_valid, b_res_taken;
    logic       b_pred_ready, b_upd_valid, b_upd_taken, b_mispredict, b_err_underflow;
    logic [1:0] b_occupancy;
    logic [1:0] b_hit_count, b_miss_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_resolver #(.DEPTH(4), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .mispredict(mispredict),
        .occupancy(occupancy), .hit_count(hit_count), .miss_count(miss_count),
        .err_underflow(err_underflow)
    );

    branch_resolver #(.DEPTH(2), .CW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(b_pred_valid), .pred_taken(b_pred_taken), .pred_ready(b_pred_ready),
        .res_valid(b_res_valid), .res_taken(b_res_taken),
        .upd_valid(b_upd_valid), .upd_taken(b_upd_taken), .mispredict(b_mispredict),
        .occupancy(b_occupancy), .hit_count(b_hit_count), .miss_count(b_miss_count),
        .err_underflow(b_err_underflow)
    );

    typedef struct {
        int pv, pt, rv, rt;
        int uv, ut, mp, occ, rdy, hit, miss, err;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int pv, pt, rv, rt, uv, ut, mp, occ, rdy, hit, miss, err);
        vec_t v;
        v.pv = pv; v.pt = pt; v.rv = rv; v.rt = rt;
        v.uv = uv; v.ut = ut; v.mp = mp; v.occ = occ;
        v.rdy = rdy; v.hit = hit; v.miss = miss; v.err = err;
        return v;
    endfunction

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " upd_valid"},     32'(upd_valid),     v.uv);
        check({tag, " upd_taken"},     32'(upd_taken),     v.ut);
        check({tag, " mispredict"},    32'(mispredict),    v.mp);
        check({tag, " occupancy"},     32'(occupancy),     v.occ);
        check({tag, " pred_ready"},    32'(pred_ready),    v.rdy);
        check({tag, " hit_count"},     32'(hit_count),     v.hit);
        check({tag, " miss_count"},    32'(miss_count),    v.miss);
        check({tag, " err_underflow"}, 32'(err_underflow), v.err);
    endtask

    task automatic step(input vec_t v);
        pred_valid = v.pv[0];
        pred_taken = v.pt[0];
        res_valid  = v.rv[0];
        res_taken  = v.rt[0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                 pv pt rv rt  uv ut mp occ rdy hit miss err
        // Resolve T,T,N in order, all correct.
        vecs[0]  = mk(1, 1, 0, 0,  0, 0, 0, 1, 1,  0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0,  0, 0, 0, 2, 1,  0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0,  0, 0, 0, 3, 1,  0, 0, 0);
        vecs[3]  = mk(0, 0, 1, 1,  1, 1, 0, 2, 1,  1, 0, 0);
        vecs[4]  = mk(0, 0, 1, 1,  1, 1, 0, 1, 1,  2, 0, 0);
        vecs[5]  = mk(0, 0, 1, 0,  1, 0, 0, 0, 1,  3, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 1,  3, 0, 0);
        // Mispredict flushes three entries and discards the same-cycle push.
        vecs[7]  = mk(1, 1, 0, 0,  0, 0, 0, 1, 1,  3, 0, 0);
        vecs[8]  = mk(1, 1, 0, 0,  0, 0, 0, 2, 1,  3, 0, 0);
        vecs[9]  = mk(1, 1, 0, 0,  0, 0, 0, 3, 1,  3, 0, 0);
        vecs[10] = mk(1, 1, 1, 0,  1, 0, 1, 0, 1,  3, 1, 0);
        vecs[11] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1,  3, 1, 0);
        // Fill to DEPTH, fifth push dropped, pop while full refuses the push.
        vecs[12] = mk(1, 1, 0, 0,  0, 0, 0, 1, 1,  3, 1, 0);
        vecs[13] = mk(1, 1, 0, 0,  0, 0, 0, 2, 1,  3, 1, 0);
        vecs[14] = mk(1, 1, 0, 0,  0, 0, 0, 3, 1,  3, 1, 0);
        vecs[15] = mk(1, 1, 0, 0,  0, 0, 0, 4, 0,  3, 1, 0);
        vecs[16] = mk(1, 0, 0, 0,  0, 0, 0, 4, 0,  3, 1, 0);
        vecs[17] = mk(1, 0, 1, 1,  1, 1, 0, 3, 1,  4, 1, 0);
        vecs[18] = mk(0, 0, 1, 1,  1, 1, 0, 2, 1,  5, 1, 0);
        vecs[19] = mk(0, 0, 1, 1,  1, 1, 0, 1, 1,  6, 1, 0);
        vecs[20] = mk(0, 0, 1, 1,  1, 1, 0, 0, 1,  7, 1, 0);
        // Correct pop with simultaneous push keeps count; the pushed entry survives.
        vecs[21] = mk(1, 0, 0, 0,  0, 1, 0, 1, 1,  7, 1, 0);
        vecs[22] = mk(1, 1, 1, 0,  1, 0, 0, 1, 1,  8, 1, 0);
        vecs[23] = mk(0, 0, 1, 1,  1, 1, 0, 0, 1,  9, 1, 0);
        // Underflow: sticky error, no update pulse, same-cycle push proceeds.
        vecs[24] = mk(1, 0, 1, 1,  0, 1, 0, 1, 1,  9, 1, 1);
        vecs[25] = mk(0, 0, 0, 0,  0, 1, 0, 1, 1,  9, 1, 1);
        vecs[26] = mk(0, 0, 1, 0,  1, 0, 0, 0, 1, 10, 1, 1);
        // Preload for the mid-cycle reset: four entries, one popped, three left.
        vecs[27] = mk(1, 1, 0, 0,  0, 0, 0, 1, 1, 10, 1, 1);
        vecs[28] = mk(1, 1, 0, 0,  0, 0, 0, 2, 1, 10, 1, 1);
        vecs[29] = mk(1, 1, 0, 0,  0, 0, 0, 3, 1, 10, 1, 1);
        vecs[30] = mk(1, 1, 0, 0,  0, 0, 0, 4, 0, 10, 1, 1);
        vecs[31] = mk(0, 0, 1, 1,  1, 1, 0, 3, 1, 11, 1, 1);

        rst_n = 1'b0;
        pred_valid = 1'b0; pred_taken = 1'b0; res_valid = 1'b0; res_taken = 1'b0;
        b_pred_valid = 1'b0; b_pred_taken = 1'b0; b_res_valid = 1'b0; b_res_taken = 1'b0;

        #2;
        check_all("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        #10 rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i]);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset between edges with three entries queued.
        pred_valid = 1'b0; res_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check_all("async_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("after_release", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        step(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        check_all("post_reset_resolve", mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check_all("post_reset_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));

        // Saturation on the 2-bit-counter instance: hit_count 1, 2 (=max-1), 3 (=max), then held.
        b_pred_valid = 1'b1; b_pred_taken = 1'b1;
        @(posedge clk); #1;
        check("sat preload occupancy", 32'(b_occupancy), 1);
        b_res_valid = 1'b1; b_res_taken = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("sat hit_count k=%0d", k), 32'(b_hit_count), (k < 3) ? k : 3);
            check($sformatf("sat upd_valid k=%0d", k), 32'(b_upd_valid), 1);
            check($sformatf("sat occupancy k=%0d", k), 32'(b_occupancy), 1);
        end
        check("sat miss_count", 32'(b_miss_count), 0);
        b_pred_valid = 1'b0; b_res_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter: DEPTH, 4, number of outstanding unresolved predictions held (power of two, 2..16).
REQ-002 Parameter: CW, 16, width of hit and miss statistic counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 pred_valid  input  1  saturating-counter predictor issued a prediction this cycle.
REQ-006 pred_taken  input  1  predicted direction (1 = taken).
REQ-007 pred_ready  output  1  queue can accept a prediction; equals (count < DEPTH) from registered count only.
REQ-008 res_valid  input  1  execute stage resolved the oldest in-flight branch this cycle.
REQ-009 res_taken  input  1  actual branch direction.
REQ-010 upd_valid  output  1  registered one-cycle pulse; drives the predictor's result input.
REQ-011 upd_taken  output  1  registered actual direction; drives the predictor's taken input.
REQ-012 mispredict  output  1  registered one-cycle pulse; resolved direction differed from queued prediction.
REQ-013 occupancy  output  clog2(DEPTH)+1  current queue entry count.
REQ-014 hit_count  output  CW  saturating count of correct predictions.
REQ-015 miss_count  output  CW  saturating count of mispredictions.
REQ-016 err_underflow  output  1  sticky flag: res_valid seen while queue empty.

Function
REQ-017 Queue SHALL be an in-order FIFO of DEPTH 1-bit entries, head/tail pointers wrapping modulo DEPTH.
REQ-018 Push SHALL occur when pred_valid && pred_ready; pred_valid while not ready SHALL be dropped, with no state change.
REQ-019 Pop SHALL occur when res_valid && count != 0; the head entry is the compared prediction.
REQ-020 On pop, next cycle: upd_valid=1, upd_taken=res_taken, mispredict=(head != res_taken); hit_count or miss_count +1 accordingly.
REQ-021 Latency res_valid -> upd_valid/mispredict SHALL be exactly 1 cycle; outputs SHALL be 0 in all cycles without a preceding pop, except upd_taken, which holds its last value.
REQ-022 Correct-prediction pop with simultaneous push SHALL leave count unchanged; both operations SHALL take effect.
REQ-023 Mispredicting pop SHALL flush the queue: count=0, head=tail on the next edge; a push in the same cycle SHALL be discarded (wrong path).
REQ-024 Full queue: pred_ready=0 even when a pop occurs in the same cycle; no same-cycle refill.
REQ-025 res_valid with count=0 SHALL set err_underflow, produce no upd_valid, and leave counters unchanged; a same-cycle push still proceeds.
REQ-026 Counters SHALL saturate at 2^CW-1 and never wrap; pointer arithmetic SHALL wrap silently.
REQ-027 occupancy SHALL be the registered count and SHALL never exceed DEPTH.

Reset
REQ-028 rst_n low SHALL immediately clear count, pointers, upd_valid, upd_taken, mispredict, hit_count, miss_count, and err_underflow, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries; no upd_valid pulse SHALL follow for them.
REQ-030 Reset release SHALL take effect on the next rising clk; pred_ready=1 in the first cycle after release.

Verification
REQ-031 Push T,T,N; resolve T,T,N on consecutive cycles -> three upd_valid pulses, mispredict never 1, hit_count=3, occupancy 3->0.
REQ-032 Push T,T,T; resolve N at head -> mispredict=1 and upd_taken=0 one cycle later, occupancy=0, miss_count=1; a push in the resolve cycle is discarded.
REQ-033 Push 5 with DEPTH=4 -> pred_ready=0 after 4th push, 5th dropped, occupancy=4; correct pop plus push in same cycle -> push refused, occupancy=3.
REQ-034 res_valid with empty queue -> err_underflow=1 sticky, upd_valid stays 0, counters unchanged.
REQ-035 Force hit_count to 2^CW-2, then two correct resolves -> hit_count=2^CW-1, held.
REQ-036 Assert rst_n=0 between clock edges with 3 entries queued -> all outputs 0 immediately, occupancy=0, no upd_valid after release.
